// File: rtl/stream_arbiter4_pkg.sv
// Shared definitions for the four-input round-robin stream arbiter.
// Holds the state encoding, the default data width and a pointer helper.
package stream_arbiter4_pkg;

    localparam int ARB_BITS = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    // The round-robin pointer moves to the channel after the one that just finished.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/stream_arbiter4_mux4.sv
// Four-way data selector, addressed by a two-bit index.
module MUX4 #(
    parameter int W = 32
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [W-1:0] y
);

    always_comb begin
        y = d0;
        case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/stream_arbiter4_rr_pick4.sv
// Round-robin candidate search: the first valid channel starting at ptr,
// wrapping modulo 4.
module rr_pick4 (
    input  logic [3:0] valid,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] idx
);

    logic [1:0] cand;
    logic [1:0] offset;

    // Walk from the farthest offset down so the nearest valid channel wins.
    always_comb begin
        any    = |valid;
        idx    = ptr;
        cand   = ptr;
        offset = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            offset = 2'(k);
            cand   = ptr + offset;
            if (valid[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/stream_arbiter4.sv
// Four-input round-robin stream arbiter with packet locking and a registered
// output stage; a granted channel keeps the output until its last beat.
module stream_arbiter4
    import stream_arbiter4_pkg::*;
#(
    parameter int BITS = ARB_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] in0,
    input  logic [BITS-1:0] in1,
    input  logic [BITS-1:0] in2,
    input  logic [BITS-1:0] in3,
    input  logic            valid0,
    input  logic            valid1,
    input  logic            valid2,
    input  logic            valid3,
    input  logic            last0,
    input  logic            last1,
    input  logic            last2,
    input  logic            last3,
    output logic            ready0,
    output logic            ready1,
    output logic            ready2,
    output logic            ready3,
    output logic [BITS-1:0] out,
    output logic            out_last,
    output logic [1:0]      out_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            arb_state,
    output logic [1:0]      arb_ptr
);

    // Handshake: a beat transfers on a rising edge where valid and ready are
    // both high. Producers hold data/last stable while valid && !ready; the
    // output register does the same while out_valid && !out_ready. Ready never
    // depends on data, only on valids, out_valid, out_ready, state and ptr.

    arb_state_t state;
    logic [1:0] ptr;
    logic [1:0] grant;

    logic [3:0] valid_vec;
    logic [3:0] ready_vec;
    logic       pick_any;
    logic [1:0] pick_idx;
    logic [1:0] sel_idx;
    logic       slot_free;
    logic       accept;
    logic [BITS:0] sel_beat;

    assign valid_vec = {valid3, valid2, valid1, valid0};

    rr_pick4 u_pick (
        .valid (valid_vec),
        .ptr   (ptr),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    assign sel_idx   = (state == ARB_LOCK) ? grant : pick_idx;
    assign slot_free = !out_valid || out_ready;

    MUX4 #(
        .W (BITS + 1)
    ) u_mux (
        .sel (sel_idx),
        .d0  ({last0, in0}),
        .d1  ({last1, in1}),
        .d2  ({last2, in2}),
        .d3  ({last3, in3}),
        .y   (sel_beat)
    );

    // In LOCK the grantee sees ready even with valid low; the grant is never
    // pre-empted, so other channels wait.
    always_comb begin
        ready_vec = 4'b0000;
        if (!rst && slot_free && (state == ARB_LOCK || pick_any)) begin
            ready_vec[sel_idx] = 1'b1;
        end
    end

    assign {ready3, ready2, ready1, ready0} = ready_vec;
    assign accept = |(valid_vec & ready_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            ptr       <= 2'd0;
            grant     <= 2'd0;
            out       <= '0;
            out_last  <= 1'b0;
            out_src   <= 2'd0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                out       <= sel_beat[BITS-1:0];
                out_last  <= sel_beat[BITS];
                out_src   <= sel_idx;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ARB_IDLE: begin
                    if (accept) begin
                        if (sel_beat[BITS]) begin
                            ptr <= next_idx(sel_idx);
                        end else begin
                            state <= ARB_LOCK;
                            grant <= sel_idx;
                        end
                    end
                end
                ARB_LOCK: begin
                    if (accept && sel_beat[BITS]) begin
                        state <= ARB_IDLE;
                        ptr   <= next_idx(grant);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign arb_state = state;
    assign arb_ptr   = ptr;

endmodule
